btn_scan_ctrl: RTL and testbench

Scan controller for the four shared bidirectional button pads on the iCEblink40-LP1K board.
- Sequences each pad through discharge (driven low), release/settle (tri-stated) and sample phases on a fixed scan period.
- Debounces each button over consecutive scans and emits one-cycle press/release events.
- Owns one toggle LED register per button; simultaneous presses all take effect.
- Sits between the top-level pad tri-states and any consumer of button events.

---
 rtl/btn_scan_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/btn_scan_ctrl.sv | 99 +++++++++
 tb/tb_btn_scan_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_scan_pkg.sv
// Shared types and width helpers for the button scan controller.
// The FSM state enum and counter-width functions live here so both modules agree.
package btn_scan_pkg;

  typedef enum logic [1:0] {
    DISCH  = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    WAIT   = 2'd3
  } scan_state_e;

  // Phase counter width; never narrower than one bit.
  function automatic int phase_width(input int scan_period);
    return (scan_period < 2) ? 1 : $clog2(scan_period);
  endfunction

  // Debounce counter width: one spare bit so DB_SCANS=1 still gets a valid counter.
  function automatic int db_width(input int db_scans);
    return $clog2(db_scans) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: counts consecutive differing scans, then commits the
// new level and emits one-cycle press/release pulses the cycle after the change.
module btn_debounce
  import btn_scan_pkg::*;
#(
  parameter int DB_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic eval,
  input  logic raw,
  output logic state,
  output logic press,
  output logic rel
);

  localparam int CW = db_width(DB_SCANS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_SCANS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt;
  logic          state_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      state      <= 1'b0;
      state_prev <= 1'b0;
      press      <= 1'b0;
      rel        <= 1'b0;
    end else begin
      state_prev <= state;
      press      <= state & ~state_prev;
      rel        <= ~state & state_prev;
      if (eval) begin
        if (raw == state) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          state <= raw;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Scan controller for shared bidirectional button pads: discharge, settle,
// sample and wait phases per scan, per-button debounce and LED toggles.
module btn_scan_ctrl
  import btn_scan_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int DISCH_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int SCAN_PERIOD   = 65536,
  parameter int DB_SCANS      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic             btn_oe,
  input  logic             led_clr,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] led,
  output logic             scan_tick
);

  localparam int PW = phase_width(SCAN_PERIOD);
  localparam logic [PW-1:0] DISCH_LAST  = PW'(DISCH_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] WAIT_LAST   = PW'(SCAN_PERIOD - DISCH_CYCLES - SETTLE_CYCLES - 2);
  localparam logic [PW-1:0] PH_ONE      = PW'(1);

  scan_state_e      state, state_next;
  logic [PW-1:0]    phase;
  logic [N_BTN-1:0] sync_a, sync_b;
  logic [N_BTN-1:0] raw;
  logic             eval;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DISCH;
      phase  <= '0;
      btn_oe <= 1'b1;
    end else begin
      state  <= state_next;
      phase  <= (state_next != state) ? '0 : phase + PH_ONE;
      // Decoded from the next state so the pad drive flips on exact phase boundaries.
      btn_oe <= (state_next == DISCH);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DISCH:   if (phase == DISCH_LAST)  state_next = SETTLE;
      SETTLE:  if (phase == SETTLE_LAST) state_next = SAMPLE;
      SAMPLE:  state_next = WAIT;
      WAIT:    if (phase == WAIT_LAST)   state_next = DISCH;
      default: state_next = DISCH;
    endcase
  end

  // Pads are active-low: a pressed button holds its pad at 0 after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a    <= '0;
      sync_b    <= '0;
      raw       <= '0;
      eval      <= 1'b0;
      scan_tick <= 1'b0;
    end else begin
      sync_a    <= btn_in;
      sync_b    <= sync_a;
      eval      <= (state == SAMPLE);
      scan_tick <= eval;
      if (state == SAMPLE) raw <= ~sync_b;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    btn_debounce #(
      .DB_SCANS(DB_SCANS)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .eval  (eval),
      .raw   (raw[i]),
      .state (btn_state[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || led_clr) begin
      led <= '0;
    end else begin
      led <= led ^ btn_press;
    end
  end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Scoreboard bench for btn_scan_ctrl with a shortened scan (4/8/32, 3 scans).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_btn_scan_ctrl;

  localparam int N_BTN = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_BTN-1:0] btn_in = 4'hF;
  logic             led_clr = 1'b0;
  logic             btn_oe;
  logic [N_BTN-1:0] btn_state, btn_press, btn_release, led;
  logic             scan_tick;

  btn_scan_ctrl #(
    .N_BTN(N_BTN), .DISCH_CYCLES(4), .SETTLE_CYCLES(8), .SCAN_PERIOD(32), .DB_SCANS(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_oe      (btn_oe),
    .led_clr     (led_clr),
    .btn_state   (btn_state),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .led         (led),
    .scan_tick   (scan_tick)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  logic [23:0] tick_q[$];  // {cycle, btn_state, led} at each scan_tick
  logic [23:0] ev_q[$];    // {cycle, btn_press, btn_release} at each event
  logic [24:0] lvl_q[$];   // {cycle, btn_oe, btn_state, led} at a given cycle
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_tick(input int c, input logic [3:0] st, input logic [3:0] ld);
    tick_q.push_back({16'(c), st, ld});
  endtask

  task automatic push_ev(input int c, input logic [3:0] pr, input logic [3:0] rl);
    ev_q.push_back({16'(c), pr, rl});
  endtask

  task automatic push_lvl(input int c, input logic oe, input logic [3:0] st, input logic [3:0] ld);
    lvl_q.push_back({16'(c), oe, st, ld});
  endtask

  always @(negedge clk) begin
    logic [23:0] e;
    logic [24:0] l;
    logic [15:0] c16;
    c16 = cyc[15:0];
    if (!rst) begin
      if (lvl_q.size() > 0 && lvl_q[0][24:9] == c16) begin
        l = lvl_q.pop_front();
        check("level", 32'({btn_oe, btn_state, led}), 32'(l[8:0]));
      end
      if (scan_tick) begin
        if (tick_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL scan_tick unexpected at cycle %0d: state %b led %b", cyc, btn_state, led);
        end else begin
          e = tick_q.pop_front();
          check("scan_tick", 32'({c16, btn_state, led}), 32'(e));
        end
      end
      if ((btn_press | btn_release) != 4'b0) begin
        if (ev_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL event unexpected at cycle %0d: press %b release %b", cyc, btn_press, btn_release);
        end else begin
          e = ev_q.pop_front();
          check("event", 32'({c16, btn_press, btn_release}), 32'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycle(input int c);
    int budget;
    budget = 0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc == c) break;
      budget++;
      if (budget > 1000) begin
        n_vec++; n_err++;
        $display("FAIL wait_cycle timeout: at %0d, expected to reach %0d", cyc, c);
        break;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    check("tick_left", 32'(tick_q.size()), 32'd0);
    check("event_left", 32'(ev_q.size()), 32'd0);
    check("level_left", 32'(lvl_q.size()), 32'd0);
    tick_q.delete();
    ev_q.delete();
    lvl_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset and scan timing, no buttons pressed.
    btn_in = 4'b1111;
    do_reset(3);
    push_lvl(0, 1'b1, 4'b0, 4'b0);
    push_lvl(3, 1'b1, 4'b0, 4'b0);
    push_lvl(4, 1'b0, 4'b0, 4'b0);
    push_lvl(12, 1'b0, 4'b0, 4'b0);
    push_lvl(31, 1'b0, 4'b0, 4'b0);
    push_lvl(32, 1'b1, 4'b0, 4'b0);
    push_lvl(35, 1'b1, 4'b0, 4'b0);
    push_lvl(36, 1'b0, 4'b0, 4'b0);
    push_lvl(64, 1'b1, 4'b0, 4'b0);
    push_tick(14, 4'b0, 4'b0);
    push_tick(46, 4'b0, 4'b0);
    push_tick(78, 4'b0, 4'b0);
    wait_cycle(90);
    drain();

    // Clean press on button 0, then reset in the middle of SETTLE.
    btn_in = 4'b1110;
    do_reset(3);
    push_tick(14, 4'b0000, 4'b0000);
    push_tick(46, 4'b0000, 4'b0000);
    push_tick(78, 4'b0001, 4'b0000);
    push_tick(110, 4'b0001, 4'b0001);
    push_ev(79, 4'b0001, 4'b0000);
    push_lvl(79, 1'b0, 4'b0001, 4'b0000);
    push_lvl(80, 1'b0, 4'b0001, 4'b0001);
    wait_cycle(134);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_lvl(0, 1'b1, 4'b0000, 4'b0000);
    push_lvl(3, 1'b1, 4'b0000, 4'b0000);
    push_lvl(4, 1'b0, 4'b0000, 4'b0000);
    push_tick(14, 4'b0000, 4'b0000);
    push_tick(46, 4'b0000, 4'b0000);
    push_tick(78, 4'b0001, 4'b0000);
    push_ev(79, 4'b0001, 4'b0000);
    wait_cycle(82);
    drain();

    // Glitch on button 1 for two scans only.
    btn_in = 4'b1101;
    do_reset(3);
    push_tick(14, 4'b0, 4'b0);
    push_tick(46, 4'b0, 4'b0);
    push_tick(78, 4'b0, 4'b0);
    push_tick(110, 4'b0, 4'b0);
    push_lvl(100, 1'b0, 4'b0, 4'b0);
    wait_cycle(64);
    btn_in = 4'b1111;
    wait_cycle(120);
    drain();

    // Simultaneous press/release of buttons 0 and 3, then led_clr racing a press of button 2.
    btn_in = 4'b0110;
    do_reset(3);
    push_tick(14, 4'b0000, 4'b0000);
    push_tick(46, 4'b0000, 4'b0000);
    push_tick(78, 4'b1001, 4'b0000);
    push_tick(110, 4'b1001, 4'b1001);
    push_tick(142, 4'b1001, 4'b1001);
    push_tick(174, 4'b0000, 4'b1001);
    push_tick(206, 4'b0000, 4'b1001);
    push_tick(238, 4'b0000, 4'b1001);
    push_tick(270, 4'b0100, 4'b1001);
    push_tick(302, 4'b0100, 4'b0000);
    push_ev(79, 4'b1001, 4'b0000);
    push_ev(175, 4'b0000, 4'b1001);
    push_ev(271, 4'b0100, 4'b0000);
    push_lvl(80, 1'b0, 4'b1001, 4'b1001);
    push_lvl(176, 1'b0, 4'b0000, 4'b1001);
    push_lvl(272, 1'b0, 4'b0100, 4'b0000);
    wait_cycle(96);
    btn_in = 4'b1111;
    wait_cycle(192);
    btn_in = 4'b1011;
    wait_cycle(271);
    led_clr = 1'b1;
    wait_cycle(272);
    led_clr = 1'b0;
    wait_cycle(310);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
